// File: rtl/solver_dispatcher_pkg.sv
// Shared definitions for the solver dispatcher: FSM states, count width
// and the round-robin index helpers used by the arbiters.
package solver_dispatcher_pkg;

    localparam int COUNT_BITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2
    } disp_state_t;

    // Index visited at step k of a search that starts at ptr.
    function automatic int rr_index(input int ptr, input int k, input int n);
        return (ptr + k) % n;
    endfunction

    // Position following idx, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/solver_dispatcher_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr wins.
// Returns a one-hot grant, the winner's index and an any-request flag.
module rr_arbiter
    import solver_dispatcher_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan all positions starting from the pointer; keep the first hit.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[rr_index(int'(ptr), k, N)]) begin
                any = 1'b1;
                grant[rr_index(int'(ptr), k, N)] = 1'b1;
                idx = IW'(rr_index(int'(ptr), k, N));
            end
        end
    end

endmodule

// File: rtl/solver_dispatcher.sv
// Dispatches a stream of pixel jobs over NUM_SOLVERS solvers and returns tagged results.
// Optional STATS_EN macro adds job and iteration counters.
module solver_dispatcher
    import solver_dispatcher_pkg::*;
#(
    parameter int NUM_SOLVERS     = 4,
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_BITS       = 32,
    parameter int ID_BITS         = 16,
    parameter int SEL_BITS        = $clog2(NUM_SOLVERS)
) (
    input  logic                              clock,
    input  logic                              reset,

    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [LIMB_INDEX_BITS-1:0]        cfg_num_limbs,
    input  logic [15:0]                       cfg_iter_lim,

    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LIMB_BITS-1:0]              in_data,
    input  logic                              in_imag,
    input  logic [LIMB_INDEX_BITS-1:0]        in_ind,
    input  logic                              in_last,
    input  logic [ID_BITS-1:0]                in_id,

    output logic [NUM_SOLVERS-1:0]            sol_wr_real_en,
    output logic [NUM_SOLVERS-1:0]            sol_wr_imag_en,
    output logic [LIMB_INDEX_BITS-1:0]        sol_wr_ind,
    output logic [LIMB_BITS-1:0]              sol_wr_data,
    output logic                              sol_num_limbs_en,
    output logic [LIMB_INDEX_BITS-1:0]        sol_num_limbs,
    output logic                              sol_iter_lim_en,
    output logic [15:0]                       sol_iter_lim,
    output logic [NUM_SOLVERS-1:0]            sol_start,
    input  logic [NUM_SOLVERS-1:0]            sol_out_ready,
    input  logic [COUNT_BITS*NUM_SOLVERS-1:0] sol_iter_count,

    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [ID_BITS-1:0]                res_id,
    output logic [COUNT_BITS-1:0]             res_count,
    output logic [SEL_BITS-1:0]               res_solver,

    output logic [31:0]                       stat_jobs,
    output logic [47:0]                       stat_iters
);

    disp_state_t                state;
    logic [SEL_BITS-1:0]        sel;
    logic [NUM_SOLVERS-1:0]     sel_oh;
    logic [ID_BITS-1:0]         job_id;
    logic [SEL_BITS-1:0]        dptr;
    logic [SEL_BITS-1:0]        rptr;

    logic [NUM_SOLVERS-1:0]     busy;
    logic [NUM_SOLVERS-1:0]     pend;
    logic [NUM_SOLVERS-1:0]     free;
    logic [NUM_SOLVERS-1:0]     done;
    logic [NUM_SOLVERS-1:0]     busy_n;
    logic [NUM_SOLVERS-1:0]     pend_n;

    logic [ID_BITS-1:0]         ids  [NUM_SOLVERS];
    logic [COUNT_BITS-1:0]      cnts [NUM_SOLVERS];

    logic [NUM_SOLVERS-1:0]     d_grant;
    logic [SEL_BITS-1:0]        d_idx;
    logic                       d_any;
    logic [NUM_SOLVERS-1:0]     r_grant;
    logic [SEL_BITS-1:0]        r_idx;
    logic                       r_any;

    logic                       cfg_take;
    logic                       word_take;
    logic                       res_load;
    logic                       res_fire;

    assign free      = ~busy & ~pend;
    assign done      = busy & sol_out_ready;
    assign cfg_take  = (state == ST_IDLE) && cfg_valid && !(|busy);
    assign word_take = (state == ST_LOAD) && in_valid;
    assign res_fire  = res_valid && res_ready;
    assign res_load  = r_any && (!res_valid || res_ready);

    rr_arbiter #(
        .N  (NUM_SOLVERS),
        .IW (SEL_BITS)
    ) u_job_arb (
        .req   (free),
        .ptr   (dptr),
        .grant (d_grant),
        .idx   (d_idx),
        .any   (d_any)
    );

    rr_arbiter #(
        .N  (NUM_SOLVERS),
        .IW (SEL_BITS)
    ) u_res_arb (
        .req   (pend),
        .ptr   (rptr),
        .grant (r_grant),
        .idx   (r_idx),
        .any   (r_any)
    );

    // Config broadcast and limb write strobes follow the accepting cycle.
    always_comb begin
        cfg_ready        = cfg_take;
        sol_num_limbs_en = cfg_take;
        sol_iter_lim_en  = cfg_take;
        sol_num_limbs    = cfg_take ? cfg_num_limbs : '0;
        sol_iter_lim     = cfg_take ? cfg_iter_lim : '0;
        in_ready         = (state == ST_LOAD);
        sol_wr_real_en   = (word_take && !in_imag) ? sel_oh : '0;
        sol_wr_imag_en   = (word_take && in_imag) ? sel_oh : '0;
        sol_wr_ind       = word_take ? in_ind : '0;
        sol_wr_data      = word_take ? in_data : '0;
        sol_start        = (state == ST_START) ? sel_oh : '0;
    end

    // Next busy/pend: start sets busy, completion moves busy to pend,
    // loading the result register retires the pend bit.
    always_comb begin
        busy_n = busy & ~done;
        if (state == ST_START) begin
            busy_n = busy_n | sel_oh;
        end
        pend_n = pend | done;
        if (res_load) begin
            pend_n = pend_n & ~r_grant;
        end
    end

    // Dispatch FSM: wait for a free solver, stream its limbs, pulse start.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            sel    <= '0;
            sel_oh <= '0;
            job_id <= '0;
            dptr   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!cfg_take && in_valid && d_any) begin
                        state  <= ST_LOAD;
                        sel    <= d_idx;
                        sel_oh <= d_grant;
                        job_id <= in_id;
                    end
                end
                ST_LOAD: begin
                    if (in_valid && in_last) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_IDLE;
                    dptr  <= SEL_BITS'(rr_next(int'(sel), NUM_SOLVERS));
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-solver occupancy flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= '0;
            pend <= '0;
        end else begin
            busy <= busy_n;
            pend <= pend_n;
        end
    end

    // Tag on start, iteration count on completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                ids[i]  <= '0;
                cnts[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                if (state == ST_START && sel_oh[i]) begin
                    ids[i] <= job_id;
                end
                if (done[i]) begin
                    cnts[i] <= sol_iter_count[COUNT_BITS*i +: COUNT_BITS];
                end
            end
        end
    end

    // Result register: refill from the pending winner when empty or draining.
    always_ff @(posedge clock) begin
        if (reset) begin
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_count  <= '0;
            res_solver <= '0;
            rptr       <= '0;
        end else if (res_load) begin
            res_valid  <= 1'b1;
            res_id     <= ids[r_idx];
            res_count  <= cnts[r_idx];
            res_solver <= r_idx;
            rptr       <= SEL_BITS'(rr_next(int'(r_idx), NUM_SOLVERS));
        end else if (res_fire) begin
            res_valid  <= 1'b0;
        end
    end

`ifdef STATS_EN
    // Running totals of started jobs and returned iterations.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_jobs  <= '0;
            stat_iters <= '0;
        end else begin
            if (state == ST_START) begin
                stat_jobs <= stat_jobs + 32'd1;
            end
            if (res_fire) begin
                stat_iters <= stat_iters + 48'(res_count);
            end
        end
    end
`else
    assign stat_jobs  = '0;
    assign stat_iters = '0;
`endif

endmodule

// File: tb/tb_solver_dispatcher.sv
// Scoreboard bench for solver_dispatcher: job dispatch, stalls,
// result ordering under backpressure, config gating and reset.
module tb_solver_dispatcher;

    localparam int N = 4;

    typedef struct packed {
        logic [15:0] id;
        logic [15:0] cnt;
        logic [1:0]  sol;
    } res_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [5:0]  cfg_num_limbs = '0;
    logic [15:0] cfg_iter_lim = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_imag = 1'b0;
    logic [5:0]  in_ind = '0;
    logic        in_last = 1'b0;
    logic [15:0] in_id = '0;
    logic [3:0]  sol_wr_real_en;
    logic [3:0]  sol_wr_imag_en;
    logic [5:0]  sol_wr_ind;
    logic [31:0] sol_wr_data;
    logic        sol_num_limbs_en;
    logic [5:0]  sol_num_limbs;
    logic        sol_iter_lim_en;
    logic [15:0] sol_iter_lim;
    logic [3:0]  sol_start;
    logic [3:0]  sol_out_ready = '0;
    logic [63:0] sol_iter_count = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_id;
    logic [15:0] res_count;
    logic [1:0]  res_solver;
    logic [31:0] stat_jobs;
    logic [47:0] stat_iters;

    res_t        sb[$];
    int          pass_n = 0;
    int          total_n = 0;
    int          jobs_n = 0;
    logic [47:0] iters_n = '0;

    solver_dispatcher dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_num_limbs(cfg_num_limbs), .cfg_iter_lim(cfg_iter_lim),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_imag(in_imag), .in_ind(in_ind), .in_last(in_last), .in_id(in_id),
        .sol_wr_real_en(sol_wr_real_en), .sol_wr_imag_en(sol_wr_imag_en),
        .sol_wr_ind(sol_wr_ind), .sol_wr_data(sol_wr_data),
        .sol_num_limbs_en(sol_num_limbs_en), .sol_num_limbs(sol_num_limbs),
        .sol_iter_lim_en(sol_iter_lim_en), .sol_iter_lim(sol_iter_lim),
        .sol_start(sol_start), .sol_out_ready(sol_out_ready),
        .sol_iter_count(sol_iter_count),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_count(res_count), .res_solver(res_solver),
        .stat_jobs(stat_jobs), .stat_iters(stat_iters)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_word(input logic [15:0] id, input int w, input int n);
        in_id   = id;
        in_data = {id, 16'(w)};
        in_imag = 1'(w % 2);
        in_ind  = 6'(w / 2);
        in_last = (w == n - 1);
    endtask

    task automatic complete(input int s, input logic [15:0] cnt);
        sol_iter_count[16*s +: 16] = cnt;
        sol_out_ready[s] = 1'b1;
        tick();
        sol_out_ready = '0;
    endtask

    task automatic send_job(input logic [15:0] id, input int n, input int exp_sol);
        int w;
        int guard;
        logic [3:0] oh;
        w = 0;
        guard = 0;
        oh = 4'(1 << exp_sol);
        drive_word(id, 0, n);
        in_valid = 1'b1;
        while (w < n && guard < 100) begin
            @(negedge clock);
            if (in_ready) begin
                total_n++;
                if (sol_wr_real_en !== (in_imag ? 4'b0 : oh))
                    $display("FAIL wr_real_en id=%0d w=%0d: got %b want %b", id, w, sol_wr_real_en, in_imag ? 4'b0 : oh);
                else pass_n++;
                total_n++;
                if (sol_wr_imag_en !== (in_imag ? oh : 4'b0))
                    $display("FAIL wr_imag_en id=%0d w=%0d: got %b want %b", id, w, sol_wr_imag_en, in_imag ? oh : 4'b0);
                else pass_n++;
                total_n++;
                if (sol_wr_ind !== 6'(w / 2) || sol_wr_data !== {id, 16'(w)})
                    $display("FAIL wr_ind_data id=%0d w=%0d: got %0d/%h want %0d/%h", id, w, sol_wr_ind, sol_wr_data, w / 2, {id, 16'(w)});
                else pass_n++;
                w++;
            end
            tick();
            guard++;
            if (w < n) drive_word(id, w, n);
            else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        total_n++;
        if (w < n) $display("FAIL load_timeout id=%0d: got %0d words want %0d", id, w, n);
        else pass_n++;
        @(negedge clock);
        total_n++;
        if (sol_start !== oh || in_ready !== 1'b0)
            $display("FAIL start_pulse id=%0d: got %b/%b want %b/0", id, sol_start, in_ready, oh);
        else pass_n++;
        jobs_n++;
        @(negedge clock);
        total_n++;
        if (sol_start !== 4'b0)
            $display("FAIL start_one_cycle id=%0d: got %b want 0000", id, sol_start);
        else pass_n++;
        tick();
    endtask

    task automatic drain(input int n);
        int got;
        int guard;
        res_t e;
        got = 0;
        guard = 0;
        res_ready = 1'b1;
        while (got < n && guard < 50) begin
            @(negedge clock);
            if (res_valid && sb.size() > 0) begin
                e = sb.pop_front();
                total_n++;
                if (res_id !== e.id || res_count !== e.cnt || res_solver !== e.sol)
                    $display("FAIL result: got id=%0d cnt=%0d sol=%0d want id=%0d cnt=%0d sol=%0d",
                             res_id, res_count, res_solver, e.id, e.cnt, e.sol);
                else pass_n++;
                iters_n = iters_n + 48'(e.cnt);
                got++;
            end
            tick();
            guard++;
        end
        res_ready = 1'b0;
        total_n++;
        if (got < n) $display("FAIL result_timeout: got %0d results want %0d", got, n);
        else pass_n++;
    endtask

    task automatic check_stats(input string tag);
        logic [31:0] ej;
        logic [47:0] ei;
`ifdef STATS_EN
        ej = 32'(jobs_n);
        ei = iters_n;
`else
        ej = '0;
        ei = '0;
`endif
        @(negedge clock);
        total_n++;
        if (stat_jobs !== ej || stat_iters !== ei)
            $display("FAIL stats_%s: got %0d/%0d want %0d/%0d", tag, stat_jobs, stat_iters, ej, ei);
        else pass_n++;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clock);
        total_n++;
        if (res_valid !== 1'b0 || in_ready !== 1'b0 || cfg_ready !== 1'b0 || sol_start !== 4'b0)
            $display("FAIL reset_ctrl: got %b%b%b %b want 000 0000", res_valid, in_ready, cfg_ready, sol_start);
        else pass_n++;
        total_n++;
        if (res_id !== 16'd0 || res_count !== 16'd0 || stat_jobs !== 32'd0 || stat_iters !== 48'd0)
            $display("FAIL reset_data: got %0d/%0d/%0d/%0d want 0/0/0/0", res_id, res_count, stat_jobs, stat_iters);
        else pass_n++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_config();
        cfg_valid = 1'b1;
        cfg_num_limbs = 6'd3;
        cfg_iter_lim = 16'd100;
        @(negedge clock);
        total_n++;
        if (cfg_ready !== 1'b1 || sol_num_limbs_en !== 1'b1 || sol_iter_lim_en !== 1'b1)
            $display("FAIL cfg_accept: got %b%b%b want 111", cfg_ready, sol_num_limbs_en, sol_iter_lim_en);
        else pass_n++;
        total_n++;
        if (sol_num_limbs !== 6'd3 || sol_iter_lim !== 16'd100)
            $display("FAIL cfg_data: got %0d/%0d want 3/100", sol_num_limbs, sol_iter_lim);
        else pass_n++;
        tick();
        cfg_valid = 1'b0;
        @(negedge clock);
        total_n++;
        if (sol_num_limbs_en !== 1'b0 || sol_iter_lim_en !== 1'b0)
            $display("FAIL cfg_pulse: got %b%b want 00", sol_num_limbs_en, sol_iter_lim_en);
        else pass_n++;
        tick();
    endtask

    task automatic test_two_jobs();
        send_job(16'd5, 8, 0);
        send_job(16'd6, 8, 1);
    endtask

    task automatic test_stall();
        send_job(16'd7, 3, 2);
        send_job(16'd8, 1, 3);
        drive_word(16'd9, 0, 2);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total_n++;
            if (in_ready !== 1'b0) $display("FAIL stall_in_ready c%0d: got %b want 0", i, in_ready);
            else pass_n++;
            tick();
        end
        in_valid = 1'b0;
        complete(2, 16'd37);
        sb.push_back('{id: 16'd7, cnt: 16'd37, sol: 2'd2});
        drain(1);
        send_job(16'd9, 2, 2);
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        jobs_n = 0;
        iters_n = '0;
        tick();
        for (int s = 0; s < N; s++) send_job(16'(20 + s), 4, s);
        sol_iter_count[16*1 +: 16] = 16'd11;
        sol_iter_count[16*3 +: 16] = 16'd33;
        sol_out_ready = 4'b1010;
        tick();
        sol_out_ready = '0;
        sb.push_back('{id: 16'd21, cnt: 16'd11, sol: 2'd1});
        sb.push_back('{id: 16'd23, cnt: 16'd33, sol: 2'd3});
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            total_n++;
            if (res_valid !== 1'b1 || res_id !== 16'd21 || res_count !== 16'd11 || res_solver !== 2'd1)
                $display("FAIL hold c%0d: got %b id=%0d cnt=%0d sol=%0d want 1 id=21 cnt=11 sol=1",
                         i, res_valid, res_id, res_count, res_solver);
            else pass_n++;
            tick();
        end
        drain(2);
    endtask

    task automatic test_cfg_busy();
        complete(2, 16'd22);
        sb.push_back('{id: 16'd22, cnt: 16'd22, sol: 2'd2});
        drain(1);
        cfg_valid = 1'b1;
        cfg_num_limbs = 6'd5;
        cfg_iter_lim = 16'd200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total_n++;
            if (cfg_ready !== 1'b0 || sol_num_limbs_en !== 1'b0)
                $display("FAIL cfg_busy c%0d: got %b%b want 00", i, cfg_ready, sol_num_limbs_en);
            else pass_n++;
            tick();
        end
        complete(0, 16'd50);
        sb.push_back('{id: 16'd20, cnt: 16'd50, sol: 2'd0});
        @(negedge clock);
        total_n++;
        if (cfg_ready !== 1'b1 || sol_iter_lim !== 16'd200)
            $display("FAIL cfg_after_done: got %b/%0d want 1/200", cfg_ready, sol_iter_lim);
        else pass_n++;
        tick();
        cfg_valid = 1'b0;
        drain(1);
        check_stats("after_results");
    endtask

    task automatic test_reset_mid_load();
        int guard;
        send_job(16'd41, 2, 0);
        drive_word(16'd40, 0, 4);
        in_valid = 1'b1;
        guard = 0;
        @(negedge clock);
        while (!in_ready && guard < 20) begin
            tick();
            @(negedge clock);
            guard++;
        end
        total_n++;
        if (sol_wr_real_en !== 4'b0010)
            $display("FAIL midload_sel: got %b want 0010", sol_wr_real_en);
        else pass_n++;
        tick();
        drive_word(16'd40, 1, 4);
        reset = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clock);
        total_n++;
        if (in_ready !== 1'b0 || sol_wr_real_en !== 4'b0 || sol_wr_imag_en !== 4'b0 ||
            sol_start !== 4'b0 || res_valid !== 1'b0)
            $display("FAIL midload_reset: got %b %b %b %b %b want all 0",
                     in_ready, sol_wr_real_en, sol_wr_imag_en, sol_start, res_valid);
        else pass_n++;
        total_n++;
        if (stat_jobs !== 32'd0 || stat_iters !== 48'd0)
            $display("FAIL midload_stats: got %0d/%0d want 0/0", stat_jobs, stat_iters);
        else pass_n++;
        reset = 1'b0;
        sb.delete();
        jobs_n = 0;
        iters_n = '0;
        tick();
        cfg_valid = 1'b1;
        @(negedge clock);
        total_n++;
        if (cfg_ready !== 1'b1) $display("FAIL busy_cleared: got cfg_ready=%b want 1", cfg_ready);
        else pass_n++;
        tick();
        cfg_valid = 1'b0;
        send_job(16'd42, 1, 0);
        check_stats("after_reset");
    endtask

    initial begin
        test_reset();
        test_config();
        test_two_jobs();
        test_stall();
        test_back_to_back();
        test_cfg_busy();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
